// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter
// Shares one Wishbone B4 classic master between the instruction-fetch port
// (read-only) and the data-memory port (load/store). One request is latched
// at a time, its bus cycle is run to ack/err/timeout, and a one-cycle done
// pulse is returned to the granted port with read data or an error flag.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   imem_req_i/addr_i            fetch request (level, held until done)
//   imem_rdata_o/done_o/err_o    fetch result, done is a 1-cycle pulse
//   dmem_req_i/we_i/addr_i/
//   dmem_wdata_i/sel_i           data request (level, held until done)
//   dmem_rdata_o/done_o/err_o    data result, done is a 1-cycle pulse
//   wb_cyc_o/stb_o/we_o/adr_o/
//   wb_dat_o/sel_o               Wishbone master outputs (all registered)
//   wb_dat_i/ack_i/err_i         Wishbone slave responses
//   busy_o                       high whenever the FSM is not idle
//
// Handshake: a port raises req with its fields stable and keeps them until it
// sees its done pulse. The bus side is classic Wishbone: cyc/stb stay high
// with constant fields until the slave answers with ack or err; responses
// seen while no cycle is running are ignored.
module wb_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_req_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_rdata_o,
  output logic        imem_done_o,
  output logic        imem_err_o,
  input  logic        dmem_req_i,
  input  logic        dmem_we_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_sel_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_done_o,
  output logic        dmem_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy_o
);

  // A zero timeout still needs a legal counter width; the comparison is
  // disabled in that case so the counter value never matters.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS_IMEM = 2'd1,
    BUS_DMEM = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] tcnt_q;
  logic          last_dmem_q;   // 1 = dmem was served last
  logic          gnt_dmem_q;    // port owning the current transaction
  logic          cyc_q;
  logic          we_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic [31:0]   imem_rdata_q;
  logic [31:0]   dmem_rdata_q;
  logic          imem_done_q;
  logic          imem_err_q;
  logic          dmem_done_q;
  logic          dmem_err_q;
  logic          busy_q;

  logic          gnt_dmem_d;
  logic          timeout_hit;
  logic          bus_err;
  logic          bus_end;

  always_comb begin
    // Alone, a port always wins; on a conflict the port not served last wins.
    gnt_dmem_d  = dmem_req_i && (!imem_req_i || !last_dmem_q);
    // A response in the final allowed cycle beats the timeout.
    timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == TO_LAST) && !wb_ack_i && !wb_err_i;
    bus_err     = wb_err_i || timeout_hit;
    bus_end     = wb_ack_i || bus_err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      last_dmem_q  <= 1'b0;
      gnt_dmem_q   <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
      imem_done_q  <= 1'b0;
      imem_err_q   <= 1'b0;
      dmem_done_q  <= 1'b0;
      dmem_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (imem_req_i || dmem_req_i) begin
            gnt_dmem_q <= gnt_dmem_d;
            cyc_q      <= 1'b1;
            busy_q     <= 1'b1;
            tcnt_q     <= '0;
            if (gnt_dmem_d) begin
              we_q    <= dmem_we_i;
              adr_q   <= dmem_addr_i;
              dat_q   <= dmem_wdata_i;
              sel_q   <= dmem_sel_i;
              state_q <= BUS_DMEM;
            end else begin
              we_q    <= 1'b0;
              adr_q   <= imem_addr_i;
              dat_q   <= '0;
              sel_q   <= 4'hF;
              state_q <= BUS_IMEM;
            end
          end
        end
        BUS_IMEM, BUS_DMEM: begin
          if (bus_end) begin
            cyc_q   <= 1'b0;
            state_q <= DONE;
            // Read data is only taken on a clean ack; an error keeps the old word.
            if (state_q == BUS_DMEM) begin
              dmem_done_q <= 1'b1;
              dmem_err_q  <= bus_err;
              if (!bus_err) dmem_rdata_q <= wb_dat_i;
            end else begin
              imem_done_q <= 1'b1;
              imem_err_q  <= bus_err;
              if (!bus_err) imem_rdata_q <= wb_dat_i;
            end
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        DONE: begin
          imem_done_q <= 1'b0;
          imem_err_q  <= 1'b0;
          dmem_done_q <= 1'b0;
          dmem_err_q  <= 1'b0;
          busy_q      <= 1'b0;
          last_dmem_q <= gnt_dmem_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_rdata_o = imem_rdata_q;
  assign imem_done_o  = imem_done_q;
  assign imem_err_o   = imem_err_q;
  assign dmem_rdata_o = dmem_rdata_q;
  assign dmem_done_o  = dmem_done_q;
  assign dmem_err_o   = dmem_err_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = sel_q;
  assign busy_o       = busy_q;

endmodule
